// File: rtl/mdu_hilo_iter.sv
// Iterative radix-2 multiply/divide unit that owns the HI/LO register pair.
// One shift-add (MUL) or restoring shift-subtract (DIV) step per cycle, then a sign-fix cycle.
module mdu_hilo_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]   a_raw_reg;
    logic               is_div_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;
    logic               b_zero_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               done_reg;
    logic               dbz_reg;

    // Opcode decode
    logic op_is_mul, op_is_div, op_is_mthi, op_is_mtlo, op_signed;
    logic accept, accept_md;

    assign op_is_mul  = (op[2:1] == 2'b00);
    assign op_is_div  = (op[2:1] == 2'b01);
    assign op_is_mthi = (op == 3'b100);
    assign op_is_mtlo = (op == 3'b101);
    assign op_signed  = ~op[0];
    assign accept     = start && (state_reg == S_IDLE);
    assign accept_md  = accept && (op_is_mul || op_is_div);

    // Operand magnitudes; unsigned ops pass raw values through
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_neg = op_signed && a[WIDTH-1];
    assign b_neg = op_signed && b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Multiply step: add multiplicand into the upper half when the multiplier LSB is set, shift right
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;

    assign mul_addend = acc_reg[0] ? mcand_reg : {WIDTH{1'b0}};
    assign mul_sum    = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    assign mul_step   = {mul_sum, acc_reg[WIDTH-1:1]};

    // Divide step: acc = {remainder, dividend/quotient}; quotient bits enter at the LSB
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_next;
    logic [2*WIDTH-1:0] div_step;

    assign div_shift    = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff     = div_shift - {1'b0, mcand_reg};
    assign div_ge       = ~div_diff[WIDTH];
    assign div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_step     = {div_rem_next, acc_reg[WIDTH-2:0], div_ge};

    // Sign-corrected results
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;
    assign quo_fix  = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    assign rem_fix  = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; cancel wins over every non-idle transition
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept_md) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_next = S_IDLE;
                end else if (cnt_reg == CNT_W'(1)) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State-decoded controls
    logic step_en, fix_en;

    always_comb begin
        busy    = 1'b0;
        step_en = 1'b0;
        fix_en  = 1'b0;
        case (state_reg)
            S_RUN: begin
                busy    = 1'b1;
                step_en = ~cancel;
            end
            S_FIX: begin
                busy   = 1'b1;
                fix_en = ~cancel;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath and HI/LO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            a_raw_reg  <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            b_zero_reg <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
            dbz_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            if (accept && op_is_mthi) begin
                hi_reg <= a;
            end
            if (accept && op_is_mtlo) begin
                lo_reg <= a;
            end

            if (accept_md) begin
                is_div_reg <= op_is_div;
                mcand_reg  <= op_is_div ? b_mag : a_mag;
                acc_reg    <= {{WIDTH{1'b0}}, (op_is_div ? a_mag : b_mag)};
                neg_q_reg  <= a_neg ^ b_neg;
                neg_r_reg  <= a_neg;
                b_zero_reg <= (b == {WIDTH{1'b0}});
                a_raw_reg  <= a;
                cnt_reg    <= CNT_W'(WIDTH);
                dbz_reg    <= 1'b0;
            end

            if (step_en) begin
                acc_reg <= is_div_reg ? div_step : mul_step;
                cnt_reg <= cnt_reg - CNT_W'(1);
            end

            if (fix_en) begin
                done_reg <= 1'b1;
                if (!is_div_reg) begin
                    {hi_reg, lo_reg} <= prod_fix;
                end else if (b_zero_reg) begin
                    // Divide by zero: architecturally defined result, no sign fixup
                    lo_reg  <= {WIDTH{1'b1}};
                    hi_reg  <= a_raw_reg;
                    dbz_reg <= 1'b1;
                end else begin
                    lo_reg <= quo_fix;
                    hi_reg <= rem_fix;
                end
            end

            if (cancel && busy) begin
                cnt_reg <= '0;
            end
        end
    end

    assign done        = done_reg;
    assign div_by_zero = dbz_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;

endmodule

// File: tb/tb_mdu_hilo_iter.sv
// Directed bench for mdu_hilo_iter at WIDTH=32: arithmetic, latency, MTHI/MTLO, cancel and reset.
module tb_mdu_hilo_iter;

    localparam int W = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cancel;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int lat;
    int bcy;
    int d0;

    mdu_hilo_iter #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .cancel      (cancel),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb);
        start = 1'b1;
        op    = o;
        a     = xa;
        b     = xb;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts negedges after the accepting edge until done; lat is in clock edges
    task automatic wait_done();
        int n;
        n   = 0;
        bcy = 0;
        while (n < 80) begin
            @(negedge clk);
            n++;
            if (busy === 1'b1) bcy++;
            if (done === 1'b1) break;
        end
        lat = n - 1;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb);
        issue(o, xa, xb);
        wait_done();
        $display("op=%b a=%h b=%h -> hi=%h lo=%h dbz=%b lat=%0d", o, xa, xb, hi, lo, div_by_zero, lat);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 3'b110;
        a      = '0;
        b      = '0;
        #7;
        check("rst_hi",   64'(hi), 64'h0);
        check("rst_lo",   64'(lo), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_dbz",  64'(div_by_zero), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: MULTU max*max, latency and busy length
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("t1_lat",  64'(lat), 64'd33);
        check("t1_busy", 64'(bcy), 64'd33);
        check("t1_hi",   64'(hi), 64'hFFFFFFFE);
        check("t1_lo",   64'(lo), 64'h00000001);

        // 2: signed multiply/divide
        run_op(OP_MULT, 32'hFFFFFFFD, 32'h00000005);
        check("t2_mult_hi", 64'(hi), 64'hFFFFFFFF);
        check("t2_mult_lo", 64'(lo), 64'hFFFFFFF1);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002);
        check("t2_div_lo", 64'(lo), 64'hFFFFFFFD);
        check("t2_div_hi", 64'(hi), 64'hFFFFFFFF);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        check("t2_ovf_lo",  64'(lo), 64'h80000000);
        check("t2_ovf_hi",  64'(hi), 64'h00000000);
        check("t2_ovf_dbz", 64'(div_by_zero), 64'h0);
        run_op(OP_DIV, 32'h00000007, 32'hFFFFFFFE);
        check("t2_div2_lo", 64'(lo), 64'hFFFFFFFD);
        check("t2_div2_hi", 64'(hi), 64'h00000001);
        run_op(OP_MULT, 32'h80000000, 32'h80000000);
        check("t2_min2_hi", 64'(hi), 64'h40000000);
        check("t2_min2_lo", 64'(lo), 64'h00000000);

        // 3: divide by zero and its clearing
        run_op(OP_DIVU, 32'h00000064, 32'h00000000);
        check("t3_dz_lo",  64'(lo), 64'hFFFFFFFF);
        check("t3_dz_hi",  64'(hi), 64'h00000064);
        check("t3_dz_flg", 64'(div_by_zero), 64'h1);
        run_op(OP_DIV, 32'hFFFFFFFB, 32'h00000000);
        check("t3_sdz_lo",  64'(lo), 64'hFFFFFFFF);
        check("t3_sdz_hi",  64'(hi), 64'hFFFFFFFB);
        check("t3_sdz_lat", 64'(lat), 64'd33);
        run_op(OP_MULTU, 32'h00000002, 32'h00000003);
        check("t3_mul_dbz", 64'(div_by_zero), 64'h0);
        check("t3_mul_lo",  64'(lo), 64'h00000006);
        check("t3_mul_hi",  64'(hi), 64'h00000000);

        // 4: MTHI then MTLO on consecutive edges
        start = 1'b1;
        op    = OP_MTHI;
        a     = 32'h12345678;
        @(posedge clk);
        #1;
        check("t4_mthi",  64'(hi), 64'h12345678);
        check("t4_busy0", 64'(busy), 64'h0);
        op = OP_MTLO;
        a  = 32'h9ABCDEF0;
        @(posedge clk);
        #1 start = 1'b0;
        check("t4_mtlo",   64'(lo), 64'h9ABCDEF0);
        check("t4_hi_kep", 64'(hi), 64'h12345678);
        check("t4_busy1",  64'(busy), 64'h0);
        $display("mthi/mtlo -> hi=%h lo=%h", hi, lo);

        // 5: MTLO while busy is ignored; cancel drops busy with no done
        d0 = done_cnt;
        issue(OP_DIVU, 32'd100, 32'd7);
        start = 1'b1;
        op    = OP_MTLO;
        a     = 32'h0000DEAD;
        @(posedge clk);
        #1 start = 1'b0;
        check("t5_mtlo_busy", 64'(lo), 64'h9ABCDEF0);
        repeat (8) @(posedge clk);
        #1 cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        check("t5_cancel_busy", 64'(busy), 64'h0);
        check("t5_cancel_hi",   64'(hi), 64'h12345678);
        check("t5_cancel_lo",   64'(lo), 64'h9ABCDEF0);
        repeat (40) @(posedge clk);
        #1;
        check("t5_no_done", 64'(done_cnt - d0), 64'd0);
        $display("cancelled divu 100/7 -> hi=%h lo=%h", hi, lo);

        // 5b: second start while busy is ignored
        d0 = done_cnt;
        issue(OP_DIVU, 32'd100, 32'd7);
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd5;
        b     = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        $display("divu 100/7 with ignored start -> hi=%h lo=%h lat=%0d", hi, lo, lat + 1);
        check("t5_ign_lat", 64'(lat), 64'd32);
        check("t5_ign_lo",  64'(lo), 64'd14);
        check("t5_ign_hi",  64'(hi), 64'd2);
        repeat (40) @(posedge clk);
        #1;
        check("t5_one_done", 64'(done_cnt - d0), 64'd1);

        // 6: asynchronous reset mid-run
        issue(OP_MULTU, 32'h11111111, 32'h00000003);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t6_rst_hi",   64'(hi), 64'h0);
        check("t6_rst_lo",   64'(lo), 64'h0);
        check("t6_rst_busy", 64'(busy), 64'h0);
        check("t6_rst_done", 64'(done), 64'h0);
        $display("async reset mid-run -> hi=%h lo=%h busy=%b", hi, lo, busy);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 6b: back-to-back start on the done cycle
        run_op(OP_MULTU, 32'd2, 32'd3);
        check("t6_b1_lo", 64'(lo), 64'd6);
        issue(OP_DIVU, 32'd100, 32'd7);
        check("t6_b2_accept", 64'(busy), 64'h1);
        wait_done();
        $display("back-to-back divu 100/7 -> hi=%h lo=%h lat=%0d", hi, lo, lat);
        check("t6_b2_lat", 64'(lat), 64'd33);
        check("t6_b2_lo",  64'(lo), 64'd14);
        check("t6_b2_hi",  64'(hi), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
